// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register holding a main entry and an
// optional skid entry. With SKID=1 it is fully registered: in_ready depends only
// on state. With SKID=0 only the main entry is used, and in_ready looks at
// out_ready combinationally. The stage also counts downstream stall cycles.
module pipe_skid_stage #(
    parameter int DW   = 64,
    parameter int CW   = 4,
    parameter int SKID = 1,
    parameter int SW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy,
    output logic [SW-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t        state, state_next;
    logic [CW-1:0] main_ctrl, main_ctrl_next, skid_ctrl, skid_ctrl_next;
    logic [DW-1:0] main_data, main_data_next, skid_data, skid_data_next;
    logic          in_xfer, out_xfer;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? (state != TWO) : (!out_valid || out_ready);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy mirrors the state: EMPTY/ONE/TWO -> 0/1/2
    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next state and entry contents; flush overrides every transfer
    always_comb begin
        state_next     = state;
        main_ctrl_next = main_ctrl;
        main_data_next = main_data;
        skid_ctrl_next = skid_ctrl;
        skid_data_next = skid_data;
        if (flush) begin
            // Data is kept so out_data holds its last value while idle
            state_next     = EMPTY;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (in_xfer) begin
                        // Only reachable with SKID=1; SKID=0 blocks input here
                        if (SKID != 0) begin
                            skid_ctrl_next = in_ctrl;
                            skid_data_next = in_data;
                            state_next     = TWO;
                        end
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_ctrl_next = skid_ctrl;
                        main_data_next = skid_data;
                        skid_ctrl_next = '0;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State and entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_next;
            main_ctrl <= main_ctrl_next;
            main_data <= main_data_next;
            skid_ctrl <= skid_ctrl_next;
            skid_data <= skid_data_next;
        end
    end

    // Saturating stall counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed testbench for pipe_skid_stage: one SKID=1 instance and one SKID=0
// instance, both with 8-bit data, 4-bit ctrl and a 4-bit stall counter.
module tb_pipe_skid_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [3:0] s_in_ctrl = '0;
    logic [7:0] s_in_data = '0;
    logic       s_in_ready, s_out_valid;
    logic [3:0] s_out_ctrl, s_stall;
    logic [7:0] s_out_data;
    logic [1:0] s_occ;

    logic       n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
    logic [3:0] n_in_ctrl = '0;
    logic [7:0] n_in_data = '0;
    logic       n_in_ready, n_out_valid;
    logic [3:0] n_out_ctrl, n_stall;
    logic [7:0] n_out_data;
    logic [1:0] n_occ;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DW(8), .CW(4), .SKID(1), .SW(4)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall)
    );

    pipe_skid_stage #(.DW(8), .CW(4), .SKID(0), .SW(4)) u_noskid (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_ctrl(n_in_ctrl), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .occupancy(n_occ), .stall_cnt(n_stall)
    );

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_in_valid = 1'b1; s_flush = 1'b1; s_in_data = 8'h55; s_in_ctrl = 4'h5;
        rst = 1'b1;
        tick();
        tick();
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
        tests++; if (s_out_ctrl !== 4'h0) begin fails++; $display("FAIL reset_out_ctrl: got %h want 0", s_out_ctrl); end
        tests++; if (s_out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", s_out_data); end
        tests++; if (s_occ !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", s_occ); end
        tests++; if (s_stall !== 4'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", s_stall); end
        s_in_valid = 1'b0; s_flush = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", s_in_ready); end
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b want 0", s_out_valid); end
    endtask

    task automatic test_streaming();
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            s_in_data = 8'(i);
            s_in_ctrl = 4'(i);
            tick();
            tests++; if (s_out_valid !== 1'b1 || s_out_data !== 8'(i)) begin fails++; $display("FAIL stream_data%0d: got v=%b d=%h want v=1 d=%h", i, s_out_valid, s_out_data, 8'(i)); end
            tests++; if (s_out_ctrl !== 4'(i)) begin fails++; $display("FAIL stream_ctrl%0d: got %h want %h", i, s_out_ctrl, 4'(i)); end
            tests++; if (s_occ !== 2'd1 || s_in_ready !== 1'b1) begin fails++; $display("FAIL stream_occ%0d: got occ=%0d rdy=%b want occ=1 rdy=1", i, s_occ, s_in_ready); end
        end
        s_in_valid = 1'b0;
        tick();
        tests++; if (s_out_valid !== 1'b0 || s_out_ctrl !== 4'h0) begin fails++; $display("FAIL stream_drain: got v=%b c=%h want v=0 c=0", s_out_valid, s_out_ctrl); end
        tests++; if (s_out_data !== 8'h03) begin fails++; $display("FAIL stream_hold_data: got %h want 03", s_out_data); end
    endtask

    task automatic test_backpressure();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1; s_in_data = 8'h0A; s_in_ctrl = 4'h1;
        tick();
        s_in_data = 8'h0B; s_in_ctrl = 4'h2;
        tick();
        tests++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0) begin fails++; $display("FAIL bp_full: got occ=%0d rdy=%b want occ=2 rdy=0", s_occ, s_in_ready); end
        tests++; if (s_out_data !== 8'h0A || s_out_ctrl !== 4'h1) begin fails++; $display("FAIL bp_head: got d=%h c=%h want d=0A c=1", s_out_data, s_out_ctrl); end
        s_in_data = 8'h0C; s_in_ctrl = 4'h3;
        tick();
        tests++; if (s_occ !== 2'd2 || s_out_data !== 8'h0A) begin fails++; $display("FAIL bp_stable: got occ=%0d d=%h want occ=2 d=0A", s_occ, s_out_data); end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        tick();
        tests++; if (s_out_data !== 8'h0B || s_out_ctrl !== 4'h2 || s_occ !== 2'd1) begin fails++; $display("FAIL bp_second: got d=%h c=%h occ=%0d want d=0B c=2 occ=1", s_out_data, s_out_ctrl, s_occ); end
        tick();
        tests++; if (s_out_valid !== 1'b0 || s_out_data !== 8'h0B) begin fails++; $display("FAIL bp_no_extra: got v=%b d=%h want v=0 d=0B", s_out_valid, s_out_data); end
    endtask

    task automatic test_flush();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1; s_in_data = 8'h21; s_in_ctrl = 4'h3;
        tick();
        s_in_data = 8'h22; s_in_ctrl = 4'h4;
        tick();
        s_flush = 1'b1; s_in_data = 8'hFF; s_in_ctrl = 4'hF;
        tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        tests++; if (s_out_valid !== 1'b0 || s_out_ctrl !== 4'h0 || s_occ !== 2'd0) begin fails++; $display("FAIL flush_empty: got v=%b c=%h occ=%0d want v=0 c=0 occ=0", s_out_valid, s_out_ctrl, s_occ); end
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", s_in_ready); end
        s_out_ready = 1'b1;
        tick();
        tests++; if (s_out_valid !== 1'b0 || s_out_data === 8'hFF) begin fails++; $display("FAIL flush_discard: got v=%b d=%h want v=0 d!=FF", s_out_valid, s_out_data); end
    endtask

    task automatic test_stall_count();
        do_reset();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1; s_in_data = 8'h33; s_in_ctrl = 4'h1;
        tick();
        s_in_valid = 1'b0;
        tests++; if (s_stall !== 4'd0) begin fails++; $display("FAIL stall_start: got %0d want 0", s_stall); end
        for (int i = 0; i < 14; i++) tick();
        tests++; if (s_stall !== 4'd14) begin fails++; $display("FAIL stall_14: got %0d want 14", s_stall); end
        for (int i = 0; i < 6; i++) tick();
        tests++; if (s_stall !== 4'd15) begin fails++; $display("FAIL stall_sat: got %0d want 15", s_stall); end
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        tests++; if (s_stall !== 4'd15 || s_occ !== 2'd0) begin fails++; $display("FAIL stall_flush: got cnt=%0d occ=%0d want cnt=15 occ=0", s_stall, s_occ); end
        do_reset();
        tests++; if (s_stall !== 4'd0) begin fails++; $display("FAIL stall_rst: got %0d want 0", s_stall); end
    endtask

    task automatic test_mid_reset();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1; s_in_data = 8'h44; s_in_ctrl = 4'h2;
        tick();
        s_in_data = 8'h45;
        tick();
        tests++; if (s_occ !== 2'd2) begin fails++; $display("FAIL midrst_fill: got occ=%0d want 2", s_occ); end
        rst = 1'b1;
        tick();
        rst = 1'b0; s_in_valid = 1'b0;
        tests++; if (s_out_valid !== 1'b0 || s_out_data !== 8'h00 || s_occ !== 2'd0) begin fails++; $display("FAIL midrst_state: got v=%b d=%h occ=%0d want v=0 d=00 occ=0", s_out_valid, s_out_data, s_occ); end
        tests++; if (s_in_ready !== 1'b1 || s_stall !== 4'd0) begin fails++; $display("FAIL midrst_rdy_cnt: got rdy=%b cnt=%0d want rdy=1 cnt=0", s_in_ready, s_stall); end
    endtask

    task automatic test_no_skid();
        do_reset();
        n_out_ready = 1'b0;
        n_in_valid  = 1'b1; n_in_data = 8'h11; n_in_ctrl = 4'h1;
        tick();
        n_in_valid = 1'b0;
        #1;
        tests++; if (n_in_ready !== 1'b0 || n_occ !== 2'd1) begin fails++; $display("FAIL noskid_block: got rdy=%b occ=%0d want rdy=0 occ=1", n_in_ready, n_occ); end
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1; n_in_data = 8'h22; n_in_ctrl = 4'h2;
        #1;
        tests++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL noskid_comb_rdy: got %b want 1", n_in_ready); end
        tick();
        tests++; if (n_out_data !== 8'h22 || n_out_ctrl !== 4'h2 || n_occ !== 2'd1) begin fails++; $display("FAIL noskid_swap: got d=%h c=%h occ=%0d want d=22 c=2 occ=1", n_out_data, n_out_ctrl, n_occ); end
        n_out_ready = 1'b0;
        n_in_data = 8'h33;
        tick();
        n_in_valid = 1'b0;
        tests++; if (n_out_data !== 8'h22 || n_occ !== 2'd1) begin fails++; $display("FAIL noskid_never_two: got d=%h occ=%0d want d=22 occ=1", n_out_data, n_occ); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_count();
        test_mid_reset();
        test_no_skid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
